// File: rtl/down_timer_pkg.sv
// Shared constants and state encoding for the down_timer block.
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/irq_latch.sv
// Sticky interrupt flag: set wins over clear when both are asserted.
module irq_latch (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic irq
);

  always_ff @(posedge clk) begin
    if (rst)      irq <= 1'b0;
    else if (set) irq <= 1'b1;
    else if (clr) irq <= 1'b0;
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter with terminal-count pulse and sticky irq.
// Optional auto-reload is compiled in with macro DOWN_TIMER_AUTORELOAD_EN.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             irq_ack,
`ifdef DOWN_TIMER_AUTORELOAD_EN
  input  logic             autoreload,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             irq,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;
  logic             irq_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    irq_set     = 1'b0;
    if (load) begin
      // A load always wins, so a coinciding terminal decrement is dropped.
      count_next  = data;
      reload_next = data;
      state_next  = (data != '0) ? RUN : IDLE;
    end else if (state_reg == RUN && enable) begin
      if (count_reg > WIDTH'(1)) begin
        count_next = count_reg - WIDTH'(1);
      end else if (count_reg == WIDTH'(1)) begin
        tc_next = 1'b1;
        irq_set = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        if (autoreload) begin
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = EXPIRED;
        end
`else
        count_next = '0;
        state_next = EXPIRED;
`endif
      end
    end
  end

  // irq is registered on the same edge as tc, so both rise together.
  irq_latch u_irq_latch (
    .clk (clk),
    .rst (rst),
    .set (irq_set),
    .clr (irq_ack),
    .irq (irq)
  );

  assign count = count_reg;
  assign tc    = tc_reg;
  assign busy  = (state_reg == RUN);

endmodule
